// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 64-bit data memory between instruction fetch and load/store.
// Round-robin arbitration, fixed read latency, one-cycle done pulse back to the owner.
module mem_port_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(RD_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        owner_q;
    logic        last_grant;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] d_word;
    logic [31:0] if_word;
    logic        grant_any;
    logic        grant_data;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_any  = if_req | d_req;
        grant_data = d_req & (~if_req | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= 64'd0;
            wdata_q    <= 64'd0;
            d_word     <= 64'd0;
            if_word    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner_q    <= grant_data;
                        last_grant <= grant_data;
                        addr_q     <= grant_data ? d_addr : if_addr;
                        cnt        <= 4'd0;
                        if (grant_data) begin
                            wdata_q <= d_wdata;
                        end
                        state <= (grant_data & d_we) ? WRITE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        // Fetch keeps its own selected half so a later data access cannot disturb it.
                        if (owner_q) begin
                            d_word <= mem_rdata;
                        end else begin
                            if_word <= addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        owner     = owner_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wr    = (state == WRITE);
        if_done   = (state == RESP) & ~owner_q;
        d_done    = (state == RESP) & owner_q;
        if_rdata  = if_word;
        d_rdata   = d_word;
    end

endmodule
